// File: rtl/bs_job_arbiter.sv
// ---------------------------------------------------------------------------
// bs_job_arbiter
//
// Shares one Black-Scholes pricing engine among NREQ requesters. Requesters
// are granted round-robin, one job at a time. The granted job's operands are
// registered toward the engine, the engine is started with a one-cycle pulse,
// and its result is returned through a single valid/ready response port,
// tagged with the index of the requester that owns it.
//
// Optional feature: define BS_ARB_TIMEOUT_EN to enable a watchdog that
// aborts a job after TIMEOUT cycles in WAIT (rsp_err=1, rsp_price=0).
// Without it, WAIT lasts until eng_done and rsp_err is tied 0.
//
// Parameters
//   WIDTH    operand/result width (Q16.16 signed)
//   NREQ     number of requesters (2..16)
//   TIMEOUT  watchdog limit in WAIT cycles (BS_ARB_TIMEOUT_EN only)
//   IDW      derived, width of rsp_id
//
// Ports
//   clk, reset                     clock, async active-high reset
//   req_valid / req_ready          per-requester job handshake
//   req_S0..req_r, req_otype       flattened requester operands
//   eng_start                      one-cycle engine start pulse
//   eng_S0..eng_r, eng_otype       registered operands to engine
//   eng_price, eng_done            engine result and completion
//   rsp_valid / rsp_ready          response handshake
//   rsp_id, rsp_price, rsp_err     response payload
//
// States
//   state  | meaning
//   IDLE   | no job; grant next valid requester, latch its operands
//   ISSUE  | pulse eng_start
//   WAIT   | wait for eng_done (first cycle ignores done)
//   RESP   | hold response until rsp_ready
// ---------------------------------------------------------------------------
module bs_job_arbiter #(
    parameter  int WIDTH   = 32,
    parameter  int NREQ    = 4,
    parameter  int TIMEOUT = 4096,
    localparam int IDW     = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_S0,
    input  logic [NREQ*WIDTH-1:0] req_K,
    input  logic [NREQ*WIDTH-1:0] req_T,
    input  logic [NREQ*WIDTH-1:0] req_sigma,
    input  logic [NREQ*WIDTH-1:0] req_r,
    input  logic [NREQ-1:0]       req_otype,
    output logic                  eng_start,
    output logic [WIDTH-1:0]      eng_S0,
    output logic [WIDTH-1:0]      eng_K,
    output logic [WIDTH-1:0]      eng_T,
    output logic [WIDTH-1:0]      eng_sigma,
    output logic [WIDTH-1:0]      eng_r,
    output logic                  eng_otype,
    input  logic [WIDTH-1:0]      eng_price,
    input  logic                  eng_done,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_price,
    output logic                  rsp_err
);

    if (NREQ < 2 || NREQ > 16 || TIMEOUT < 1) begin : g_param_check
        $error("bs_job_arbiter: NREQ must be 2..16 and TIMEOUT at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   last_q;
    logic [IDW-1:0]   gid_q;
    logic             first_q;
    logic [WIDTH-1:0] s0_q, k_q, t_q, sigma_q, r_q;
    logic             otype_q;
    logic [WIDTH-1:0] price_q;
    logic             err_q;

    logic             any_valid;
    logic [IDW-1:0]   gnt_idx;
    logic             grant_en;
    logic             cap_en;
    logic             abort_en;
    logic [WIDTH-1:0] sel_s0, sel_k, sel_t, sel_sigma, sel_r;
    logic             sel_otype;

    // Rotating priority search starting just after the last grant.
    always_comb begin
        int idx;
        any_valid = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = int'(last_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!any_valid && req_valid[IDW'(idx)]) begin
                any_valid = 1'b1;
                gnt_idx   = IDW'(idx);
            end
        end
    end

    // Operand mux for the granted requester (constant slices after unroll).
    always_comb begin
        sel_s0    = '0;
        sel_k     = '0;
        sel_t     = '0;
        sel_sigma = '0;
        sel_r     = '0;
        sel_otype = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == IDW'(i)) begin
                sel_s0    = req_S0[i*WIDTH +: WIDTH];
                sel_k     = req_K[i*WIDTH +: WIDTH];
                sel_t     = req_T[i*WIDTH +: WIDTH];
                sel_sigma = req_sigma[i*WIDTH +: WIDTH];
                sel_r     = req_r[i*WIDTH +: WIDTH];
                sel_otype = req_otype[i];
            end
        end
    end

`ifdef BS_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (state_q == S_ISSUE) begin
            cnt_q <= '0;
        end else if (state_q == S_WAIT) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    logic timeout_hit;
    assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));
`else
    logic timeout_hit;
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        grant_en  = 1'b0;
        cap_en    = 1'b0;
        abort_en  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (any_valid) begin
                    req_ready[gnt_idx] = 1'b1;
                    grant_en           = 1'b1;
                    state_d            = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                // first_q masks a done level left over from the previous job
                if (!first_q && eng_done) begin
                    cap_en  = 1'b1;
                    state_d = S_RESP;
                end else if (timeout_hit) begin
                    abort_en = 1'b1;
                    state_d  = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            last_q  <= IDW'(NREQ - 1);
            gid_q   <= '0;
            first_q <= 1'b0;
            s0_q    <= '0;
            k_q     <= '0;
            t_q     <= '0;
            sigma_q <= '0;
            r_q     <= '0;
            otype_q <= 1'b0;
            price_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= (state_q == S_ISSUE);
            if (grant_en) begin
                last_q  <= gnt_idx;
                gid_q   <= gnt_idx;
                s0_q    <= sel_s0;
                k_q     <= sel_k;
                t_q     <= sel_t;
                sigma_q <= sel_sigma;
                r_q     <= sel_r;
                otype_q <= sel_otype;
            end
            if (cap_en) begin
                price_q <= eng_price;
                err_q   <= 1'b0;
            end else if (abort_en) begin
                price_q <= '0;
                err_q   <= 1'b1;
            end
        end
    end

    assign eng_start = (state_q == S_ISSUE);
    assign eng_S0    = s0_q;
    assign eng_K     = k_q;
    assign eng_T     = t_q;
    assign eng_sigma = sigma_q;
    assign eng_r     = r_q;
    assign eng_otype = otype_q;
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_id    = gid_q;
    assign rsp_price = price_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_bs_job_arbiter.sv
module tb_bs_job_arbiter;
    localparam int WIDTH   = 32;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 16;
    localparam int IDW     = 2;
    localparam int LAT     = 13;   // accept -> rsp_valid with the 10-cycle stub

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_S0 = '0, req_K = '0, req_T = '0, req_sigma = '0, req_r = '0;
    logic [NREQ-1:0]       req_otype = '0;
    logic                  eng_start;
    logic [WIDTH-1:0]      eng_S0, eng_K, eng_T, eng_sigma, eng_r;
    logic                  eng_otype;
    logic [WIDTH-1:0]      eng_price;
    logic                  eng_done;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b1;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_price;
    logic                  rsp_err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    bs_job_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_S0(req_S0), .req_K(req_K), .req_T(req_T),
        .req_sigma(req_sigma), .req_r(req_r), .req_otype(req_otype),
        .eng_start(eng_start),
        .eng_S0(eng_S0), .eng_K(eng_K), .eng_T(eng_T),
        .eng_sigma(eng_sigma), .eng_r(eng_r), .eng_otype(eng_otype),
        .eng_price(eng_price), .eng_done(eng_done),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_price(rsp_price), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stub engine: price = S0-K, done 10 cycles after start, held until next start.
    logic [WIDTH-1:0] stub_price = '0;
    logic             stub_done = 1'b0;
    logic             stub_pend = 1'b0;
    int               stub_cnt = 0;
    bit               stub_hang = 1'b0;
    bit               stub_slow_clear = 1'b0;

    always @(posedge clk) begin
        if (eng_start) begin
            stub_cnt   <= 10;
            stub_price <= eng_S0 - eng_K;
            if (stub_slow_clear) stub_pend <= 1'b1;
            else                 stub_done <= 1'b0;
        end else begin
            if (stub_pend) begin
                stub_done <= 1'b0;
                stub_pend <= 1'b0;
            end
            if (stub_cnt != 0) begin
                stub_cnt <= stub_cnt - 1;
                if (stub_cnt == 1 && !stub_hang) stub_done <= 1'b1;
            end
        end
    end
    assign eng_price = stub_price;
    assign eng_done  = stub_done;

    typedef struct {
        int          rq;
        logic [31:0] s0, k, t, sg, rr;
        bit          ot;
        logic [31:0] price;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int r, input logic [31:0] s0, k, t, sg, rr, input bit ot);
        req_S0[r*WIDTH +: WIDTH]    = s0;
        req_K[r*WIDTH +: WIDTH]     = k;
        req_T[r*WIDTH +: WIDTH]     = t;
        req_sigma[r*WIDTH +: WIDTH] = sg;
        req_r[r*WIDTH +: WIDTH]     = rr;
        req_otype[r]                = ot;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 0);
        check({tag, "_eng_start"}, 32'(eng_start), 0);
        check({tag, "_eng_ops"}, eng_S0 | eng_K | eng_T | eng_sigma | eng_r, 0);
        check({tag, "_eng_otype"}, 32'(eng_otype), 0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        check({tag, "_rsp_id"}, 32'(rsp_id), 0);
        check({tag, "_rsp_price"}, rsp_price, 0);
        check({tag, "_rsp_err"}, 32'(rsp_err), 0);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    // Entered at posedge+1; returns in cycle acc+1 at posedge+1 with valid dropped.
    task automatic submit(input vec_t v, output int acc);
        set_ops(v.rq, v.s0, v.k, v.t, v.sg, v.rr, v.ot);
        req_valid[v.rq] = 1'b1;
        acc = -1;
        for (int i = 0; i < 50 && acc < 0; i++) begin
            #1;
            if (req_ready[v.rq]) acc = cyc;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check("accept_seen", 32'(acc >= 0), 1);
        @(posedge clk);
        #1;
        req_valid[v.rq] = 1'b0;
    endtask

    task automatic wait_rsp(input int budget, output int rc);
        rc = -1;
        for (int i = 0; i < budget && rc < 0; i++) begin
            if (rsp_valid) rc = cyc;
            else step();
        end
        check("rsp_seen", 32'(rc >= 0), 1);
    endtask

    task automatic do_job(input vec_t v, input string tag);
        int acc, rc;
        submit(v, acc);
        check({tag, "_start"}, 32'(eng_start), 1);
        check({tag, "_eng_S0"}, eng_S0, v.s0);
        check({tag, "_eng_K"}, eng_K, v.k);
        check({tag, "_eng_T"}, eng_T, v.t);
        check({tag, "_eng_otype"}, 32'(eng_otype), 32'(v.ot));
        step();
        check({tag, "_start_1cyc"}, 32'(eng_start), 0);
        wait_rsp(40, rc);
        check({tag, "_latency"}, 32'(rc - acc), LAT);
        check({tag, "_rsp_id"}, 32'(rsp_id), 32'(v.rq));
        check({tag, "_rsp_price"}, rsp_price, v.price);
        check({tag, "_rsp_err"}, 32'(rsp_err), 0);
        step();
        check({tag, "_rsp_drop"}, 32'(rsp_valid), 0);
    endtask

    initial begin
        int acc, rc, prev_rc, bad;
        vec_t v;
        logic [31:0] h_price;
        logic [IDW-1:0] h_id;

        vecs[0] = '{0, 32'h00140000, 32'h00100000, 32'h00010000, 32'h00004CCD, 32'h00000666, 1'b0, 32'h00040000};
        vecs[1] = '{1, 32'h00100000, 32'h00140000, 32'h00020000, 32'h00003333, 32'h00000CCC, 1'b1, 32'hFFFC0000};
        vecs[2] = '{2, 32'h7FFF0000, 32'h00000000, 32'h00008000, 32'h00010000, 32'h00000000, 1'b0, 32'h7FFF0000};
        vecs[3] = '{3, 32'h00000001, 32'h00000001, 32'h00010000, 32'h00004CCD, 32'h00000666, 1'b1, 32'h00000000};
        vecs[4] = '{0, 32'h12345678, 32'h02345678, 32'h00030000, 32'h00002000, 32'h00000100, 1'b0, 32'h10000000};

        // Reset state (in reset, then just after release)
        step();
        check_reset_vals("rst");
        reset = 1'b0;
        step();
        check_reset_vals("post_rst");

        // Table of single jobs
        for (int i = 0; i < 5; i++) do_job(vecs[i], $sformatf("vec%0d", i));

        // Done level still high from the previous job when the new one starts
        stub_slow_clear = 1'b1;
        do_job(vecs[1], "stale_done");
        stub_slow_clear = 1'b0;

        // Round robin with all requesters valid
        apply_reset();
        for (int i = 0; i < NREQ; i++)
            set_ops(i, 32'((i + 2) << 16), 32'h00010000, 32'h00010000, 32'h00004000, 32'h0, 1'b0);
        req_valid = '1;
        prev_rc = -1;
        for (int j = 0; j < 8; j++) begin
            acc = -1;
            for (int w = 0; w < 50 && acc < 0; w++) begin
                #1;
                check("rr_onehot0", 32'($onehot0(req_ready)), 1);
                if (|req_ready) acc = cyc;
                else step();
            end
            check("rr_grant_seen", 32'(acc >= 0), 1);
            check($sformatf("rr_grant%0d", j), 32'(req_ready), 32'(1 << (j % 4)));
            if (prev_rc >= 0) check("rr_back_to_back", 32'(acc - prev_rc), 1);
            step();
            wait_rsp(40, rc);
            check($sformatf("rr_id%0d", j), 32'(rsp_id), 32'(j % 4));
            check($sformatf("rr_price%0d", j), rsp_price, 32'(((j % 4) + 1) << 16));
            prev_rc = rc;
            step();
        end
        req_valid = '0;
        step();

        // Response backpressure for 20 cycles with another requester waiting
        rsp_ready = 1'b0;
        do begin
            v = vecs[2];
            submit(v, acc);
        end while (0);
        wait_rsp(40, rc);
        h_price = rsp_price;
        h_id    = rsp_id;
        check("bp_price", h_price, vecs[2].price);
        set_ops(3, 32'h00050000, 32'h00020000, 32'h00010000, 32'h0, 32'h0, 1'b1);
        req_valid[3] = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (!rsp_valid || rsp_price !== h_price || rsp_id !== h_id || rsp_err !== 1'b0) bad++;
            if (req_ready !== '0) bad++;
            step();
        end
        check("bp_stable", 32'(bad), 0);
        check("bp_id", 32'(rsp_id), 2);
        rsp_ready = 1'b1;
        step();
        #1;
        check("bp_next_grant", 32'(req_ready), 32'h8);
        step();
        req_valid[3] = 1'b0;
        wait_rsp(40, rc);
        check("bp_next_id", 32'(rsp_id), 3);
        check("bp_next_price", rsp_price, 32'h00030000);
        step();

        // Reset 3 cycles into WAIT; stale done must be ignored afterwards
        submit(vecs[2], acc);  // now in ISSUE
        step();                // first WAIT cycle
        step();
        step();
        step();
        check("mid_rst_id_before", 32'(rsp_id), 2);
        reset = 1'b1;
        #1;
        check_reset_vals("mid_rst");
        step();
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (rsp_valid || eng_start) bad++;
        end
        check("mid_rst_stale_ignored", 32'(bad), 0);
        check("mid_rst_stub_done", 32'(eng_done), 1);
        do_job(vecs[1], "after_rst");

        // Engine that never finishes
        stub_hang = 1'b1;
        submit(vecs[0], acc);
`ifdef BS_ARB_TIMEOUT_EN
        wait_rsp(100, rc);
        check("to_latency", 32'(rc - acc), 32'(TIMEOUT + 2));
        check("to_err", 32'(rsp_err), 1);
        check("to_price", rsp_price, 0);
        check("to_id", 32'(rsp_id), 0);
        step();
`else
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            if (rsp_valid) bad++;
            step();
        end
        check("no_to_rsp_valid", 32'(bad), 0);
        check("no_to_err", 32'(rsp_err), 0);
`endif
        stub_hang = 1'b0;
        apply_reset();
        do_job(vecs[3], "final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
